// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and defaults for the gate sequencer
package gate_seq_pkg;

    localparam int N_GATE_DEF  = 5;
    localparam int CNT_W_DEF   = 32;
    localparam int SYNC_TO_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAGGER,
        ST_OPEN,
        ST_CLOSE,
        ST_DONE,
        ST_ERROR
    } gate_seq_state_t;

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// rtl/gate_seq_ctrl_if.sv - control, config and gate feedback bundle of the sequencer
interface gate_seq_ctrl_if
    import gate_seq_pkg::*;
#(
    parameter int N_GATE = N_GATE_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start_i;
    logic              stop_i;
    logic [N_GATE-1:0] chan_mask_i;
    logic [CNT_W-1:0]  gate_shift_i;
    logic [CNT_W-1:0]  gate_time_i;
    logic [N_GATE-1:0] gate_sync_i;
    logic [N_GATE-1:0] gate_en_o;
    logic              busy_o;
    logic              done_o;
    logic              abort_o;
    logic              err_o;

    modport master (
        output start_i, stop_i, chan_mask_i, gate_shift_i, gate_time_i, gate_sync_i,
        input  gate_en_o, busy_o, done_o, abort_o, err_o
    );

    modport slave (
        input  start_i, stop_i, chan_mask_i, gate_shift_i, gate_time_i, gate_sync_i,
        output gate_en_o, busy_o, done_o, abort_o, err_o
    );
endinterface

// File: rtl/gate_next_sel.sv
// rtl/gate_next_sel.sv - finds the lowest set mask bit strictly above idx
module gate_next_sel #(
    parameter int N_GATE = 5,
    parameter int IDX_W  = (N_GATE > 1) ? $clog2(N_GATE) : 1
) (
    input  logic [N_GATE-1:0] mask,
    input  logic [IDX_W-1:0]  idx,
    output logic [IDX_W-1:0]  next_idx,
    output logic              none_left
);
    // Scan downwards so the lowest qualifying bit is the last one written.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int k = N_GATE - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(idx))) begin
                next_idx  = IDX_W'(k);
                none_left = 1'b0;
            end
        end
    end
endmodule

// File: rtl/gate_seq_ctrl.sv
// rtl/gate_seq_ctrl.sv - staggered open / timed hold / close sequencer for the gate bank
module gate_seq_ctrl
    import gate_seq_pkg::*;
#(
    parameter int N_GATE  = N_GATE_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SYNC_TO = SYNC_TO_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    gate_seq_ctrl_if.slave bus
);
    localparam int IDX_W = (N_GATE > 1) ? $clog2(N_GATE) : 1;
    localparam int SC_W  = $clog2(SYNC_TO + 1);
    localparam logic [SC_W-1:0] SYNC_LIM = SC_W'(SYNC_TO - 1);

    gate_seq_state_t   state_q, state_d;
    logic [N_GATE-1:0] en_q, en_d;
    logic [N_GATE-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]  time_m1_q, time_m1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;

    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  next_idx;
    logic              none_left;
    logic              start_ok;
    logic              cur_sync;
    logic [CNT_W-1:0]  cnt_inc;

    gate_next_sel #(.N_GATE(N_GATE), .IDX_W(IDX_W)) u_next_sel (
        .mask      (mask_q),
        .idx       (idx_q),
        .next_idx  (next_idx),
        .none_left (none_left)
    );

    always_comb begin
        first_idx = '0;
        for (int k = N_GATE - 1; k >= 0; k--) begin
            if (bus.chan_mask_i[k]) first_idx = IDX_W'(k);
        end
    end

    assign start_ok = bus.start_i && !bus.stop_i && (bus.chan_mask_i != '0);
    assign cur_sync = bus.gate_sync_i[idx_q];
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mask_d     = mask_q;
        shift_d    = shift_q;
        time_m1_d  = time_m1_q;
        cnt_d      = cnt_q;
        sync_cnt_d = sync_cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        abort_d    = abort_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_ok) begin
                    state_d    = ST_STAGGER;
                    mask_d     = bus.chan_mask_i;
                    shift_d    = bus.gate_shift_i;
                    time_m1_d  = (bus.gate_time_i == '0) ? '0 : bus.gate_time_i - CNT_W'(1);
                    err_d      = 1'b0;
                    abort_d    = 1'b0;
                    idx_d      = first_idx;
                    en_d       = N_GATE'(1) << first_idx;
                    cnt_d      = '0;
                    sync_cnt_d = '0;
                end
            end
            ST_STAGGER: begin
                if (bus.stop_i) begin
                    state_d    = ST_CLOSE;
                    en_d       = '0;
                    abort_d    = 1'b1;
                    sync_cnt_d = '0;
                end else if (cur_sync && (cnt_q >= shift_q)) begin
                    cnt_d      = '0;
                    sync_cnt_d = '0;
                    if (none_left) begin
                        state_d = ST_OPEN;
                    end else begin
                        idx_d = next_idx;
                        en_d  = en_q | (N_GATE'(1) << next_idx);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (!cur_sync) begin
                        if (sync_cnt_q >= SYNC_LIM) begin
                            state_d = ST_ERROR;
                            en_d    = '0;
                            err_d   = 1'b1;
                        end else begin
                            sync_cnt_d = sync_cnt_q + SC_W'(1);
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (bus.stop_i) begin
                    state_d    = ST_CLOSE;
                    en_d       = '0;
                    abort_d    = 1'b1;
                    sync_cnt_d = '0;
                end else if ((bus.gate_sync_i & mask_q) != mask_q) begin
                    state_d = ST_ERROR;
                    en_d    = '0;
                    err_d   = 1'b1;
                end else if (cnt_q >= time_m1_q) begin
                    state_d    = ST_CLOSE;
                    en_d       = '0;
                    cnt_d      = '0;
                    sync_cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CLOSE: begin
                if ((bus.gate_sync_i & mask_q) == '0) begin
                    state_d = ST_DONE;
                end else if (sync_cnt_q >= SYNC_LIM) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    sync_cnt_d = sync_cnt_q + SC_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            en_q       <= '0;
            mask_q     <= '0;
            shift_q    <= '0;
            time_m1_q  <= '0;
            cnt_q      <= '0;
            sync_cnt_q <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mask_q     <= mask_d;
            shift_q    <= shift_d;
            time_m1_q  <= time_m1_d;
            cnt_q      <= cnt_d;
            sync_cnt_q <= sync_cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.gate_en_o = en_q;
    assign bus.busy_o    = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.abort_o   = abort_q;
    assign bus.err_o     = err_q;
endmodule
